// File: rtl/dtree_channel_arbiter.sv
// Round-robin arbiter sharing one decision-tree classifier between channels.
// Streams each granted feature vector out and tags the result or timeout.
module dtree_channel_arbiter #(
    parameter int CHANNELS = 4,
    parameter int FEATURES = 3,
    parameter int IN_WIDTH = 10,
    parameter int TIMEOUT  = 64
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [CHANNELS-1:0]                    ch_req,
    input  logic [CHANNELS*FEATURES*IN_WIDTH-1:0]  ch_features,
    output logic [CHANNELS-1:0]                    ch_grant,
    input  logic                                   dt_ready,
    output logic                                   dt_valid,
    output logic [IN_WIDTH-1:0]                    dt_sample,
    input  logic [1:0]                             dt_level,
    input  logic [1:0]                             dt_path,
    input  logic                                   dt_out_valid,
    output logic                                   res_valid,
    output logic [$clog2(CHANNELS)-1:0]            res_chan,
    output logic [1:0]                             res_level,
    output logic [1:0]                             res_path,
    output logic                                   res_timeout,
    output logic                                   busy
);

    localparam int CW  = $clog2(CHANNELS);
    localparam int CW1 = CW + 1;
    localparam int FW  = FEATURES * IN_WIDTH;
    localparam int KW  = (FEATURES > 1) ? $clog2(FEATURES) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [KW-1:0] K_LAST = KW'(FEATURES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);
    localparam logic [CW:0]   N_CH   = CW1'(CHANNELS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_ptr;
    logic [CW-1:0]         r_chan;
    logic [FW-1:0]         r_vec;
    logic [KW-1:0]         r_k;
    logic [TW-1:0]         r_cnt;
    logic                  r_dt_valid;
    logic [IN_WIDTH-1:0]   r_dt_sample;
    logic                  r_res_valid;
    logic [CW-1:0]         r_res_chan;
    logic [1:0]            r_res_level;
    logic [1:0]            r_res_path;
    logic                  r_res_timeout;

    logic                  w_found;
    logic [CW-1:0]         w_idx;
    logic [CW:0]           w_pos;
    logic [FW-1:0]         w_vec;
    logic [KW-1:0]         w_k_inc;
    logic                  w_idle;

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_pos   = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            w_pos = {1'b0, r_ptr} + CW1'(i);
            if (w_pos >= N_CH) begin
                w_pos = w_pos - N_CH;
            end
            if (ch_req[w_pos[CW-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_pos[CW-1:0];
            end
        end
    end

    assign w_idle  = (r_state == S_IDLE);
    assign w_vec   = ch_features[w_idx*FW +: FW];
    assign w_k_inc = r_k + 1'b1;

    // Grant is the combinational pulse of the latching cycle; forced low in reset.
    assign ch_grant = (w_found && w_idle && reset)
                    ? (CHANNELS'(1) << w_idx)
                    : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_chan        <= '0;
            r_vec         <= '0;
            r_k           <= '0;
            r_cnt         <= '0;
            r_dt_valid    <= 1'b0;
            r_dt_sample   <= '0;
            r_res_valid   <= 1'b0;
            r_res_chan    <= '0;
            r_res_level   <= '0;
            r_res_path    <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_chan      <= w_idx;
                        r_vec       <= w_vec;
                        r_ptr       <= (w_idx == C_LAST) ? '0 : w_idx + 1'b1;
                        r_k         <= '0;
                        r_dt_valid  <= 1'b1;
                        r_dt_sample <= w_vec[IN_WIDTH-1:0];
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (dt_ready) begin
                        if (r_k == K_LAST) begin
                            r_dt_valid <= 1'b0;
                            r_k        <= '0;
                            r_cnt      <= '0;
                            r_state    <= S_WAIT;
                        end else begin
                            r_k         <= w_k_inc;
                            r_dt_sample <= r_vec[w_k_inc*IN_WIDTH +: IN_WIDTH];
                        end
                    end
                end
                S_WAIT: begin
                    if (dt_out_valid) begin
                        r_res_valid   <= 1'b1;
                        r_res_chan    <= r_chan;
                        r_res_level   <= dt_level;
                        r_res_path    <= dt_path;
                        r_res_timeout <= 1'b0;
                        r_state       <= S_IDLE;
                    end else if (r_cnt == T_LAST) begin
                        r_res_valid   <= 1'b1;
                        r_res_chan    <= r_chan;
                        r_res_level   <= '0;
                        r_res_path    <= '0;
                        r_res_timeout <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dt_valid    = r_dt_valid;
    assign dt_sample   = r_dt_sample;
    assign res_valid   = r_res_valid;
    assign res_chan    = r_res_chan;
    assign res_level   = r_res_level;
    assign res_path    = r_res_path;
    assign res_timeout = r_res_timeout;
    assign busy        = ~w_idle;

endmodule

// File: tb/tb_dtree_channel_arbiter.sv
// Directed table-driven bench for dtree_channel_arbiter.
// Covers arbitration order, streaming, back-pressure, timeout and reset.
module tb_dtree_channel_arbiter;

    localparam int CH = 4;
    localparam int FE = 3;
    localparam int IW = 10;
    localparam int TO = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic [CH-1:0]       ch_req;
    logic [CH*FE*IW-1:0] ch_features;
    logic [CH-1:0]       ch_grant;
    logic                dt_ready;
    logic                dt_valid;
    logic [IW-1:0]       dt_sample;
    logic [1:0]          dt_level;
    logic [1:0]          dt_path;
    logic                dt_out_valid;
    logic                res_valid;
    logic [1:0]          res_chan;
    logic [1:0]          res_level;
    logic [1:0]          res_path;
    logic                res_timeout;
    logic                busy;

    dtree_channel_arbiter #(
        .CHANNELS(CH), .FEATURES(FE), .IN_WIDTH(IW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .ch_req(ch_req), .ch_features(ch_features), .ch_grant(ch_grant),
        .dt_ready(dt_ready), .dt_valid(dt_valid), .dt_sample(dt_sample),
        .dt_level(dt_level), .dt_path(dt_path), .dt_out_valid(dt_out_valid),
        .res_valid(res_valid), .res_chan(res_chan), .res_level(res_level),
        .res_path(res_path), .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] req;
        int         stall;
        int         ov;
        logic [1:0] lvl;
        logic [1:0] path;
        int         exp_ch;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int feat(input int c, input int f);
        return c * 100 + (f + 1) * 10;
    endfunction

    task automatic run_txn(input vec_t v, input bit keep);
        int  fi;
        int  cyc;
        int  w;
        bit  stalled;
        bit  to;
        to = (v.ov < 0);
        @(negedge clk);
        ch_req       = v.req;
        dt_ready     = 1'b1;
        dt_out_valid = 1'b1;
        dt_level     = 2'd3;
        dt_path      = 2'd3;
        #1;
        chk("grant", 32'(ch_grant), 32'(1 << v.exp_ch));
        fi      = 0;
        cyc     = 0;
        stalled = 1'b0;
        while (fi < FE && cyc < 20) begin
            @(negedge clk);
            if (!keep) ch_req = '0;
            #1;
            cyc++;
            dt_ready = 1'b1;
            chk("send_dv", 32'(dt_valid), 32'd1);
            chk("send_sample", 32'(dt_sample), 32'(feat(v.exp_ch, fi)));
            chk("send_res", 32'(res_valid), 32'd0);
            if (fi == v.stall && !stalled) begin
                dt_ready = 1'b0;
                stalled  = 1'b1;
            end else begin
                fi++;
            end
        end
        chk("send_cycles", 32'(cyc), 32'(FE + ((v.stall >= 0) ? 1 : 0)));
        @(negedge clk);
        #1;
        dt_out_valid = 1'b0;
        chk("wait_dv", 32'(dt_valid), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        w = 0;
        while (!res_valid && w < TO + 10) begin
            dt_out_valid = (w == v.ov);
            dt_level     = (w == v.ov) ? v.lvl : ~v.lvl;
            dt_path      = (w == v.ov) ? v.path : ~v.path;
            @(negedge clk);
            #1;
            w++;
            dt_out_valid = 1'b0;
        end
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("res_latency", 32'(w), 32'(to ? TO : v.ov + 1));
        chk("res_chan", 32'(res_chan), 32'(v.exp_ch));
        chk("res_timeout", 32'(res_timeout), 32'(to));
        chk("res_level", 32'(res_level), to ? 32'd0 : 32'(v.lvl));
        chk("res_path", 32'(res_path), to ? 32'd0 : 32'(v.path));
        chk("res_busy", 32'(busy), 32'd0);
        if (keep) chk("regrant", 32'(ch_grant), 32'(v.req));
    endtask

    initial begin
        int quiet;
        tbl[0] = '{4'b0001, -1,      2, 2'd2, 2'd1, 0};
        tbl[1] = '{4'b1111, -1,      0, 2'd1, 2'd2, 1};
        tbl[2] = '{4'b1111,  1,      5, 2'd3, 2'd3, 2};
        tbl[3] = '{4'b1111, -1,      1, 2'd0, 2'd1, 3};
        tbl[4] = '{4'b1111, -1,      3, 2'd2, 2'd2, 0};
        tbl[5] = '{4'b0100, -1,     -1, 2'd3, 2'd2, 2};
        tbl[6] = '{4'b0011, -1, TO - 1, 2'd1, 2'd3, 0};
        tbl[7] = '{4'b1010,  0,      0, 2'd2, 2'd0, 1};
        tbl[8] = '{4'b1000,  2,      4, 2'd1, 2'd1, 3};

        for (int c = 0; c < CH; c++)
            for (int f = 0; f < FE; f++)
                ch_features[(c*FE+f)*IW +: IW] = IW'(feat(c, f));

        reset        = 1'b0;
        ch_req       = 4'b1111;
        dt_ready     = 1'b0;
        dt_out_valid = 1'b0;
        dt_level     = '0;
        dt_path      = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_grant", 32'(ch_grant), 32'd0);
        chk("rst_dv", 32'(dt_valid), 32'd0);
        chk("rst_sample", 32'(dt_sample), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_chan", 32'(res_chan), 32'd0);
        chk("rst_res_level", 32'(res_level), 32'd0);
        chk("rst_res_path", 32'(res_path), 32'd0);
        chk("rst_res_to", 32'(res_timeout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        ch_req = '0;
        reset  = 1'b1;

        for (int i = 0; i < 9; i++) run_txn(tbl[i], 1'b0);

        // Held request is regranted on the result cycle, then reset lands mid-SEND.
        run_txn('{4'b0010, -1, 0, 2'd2, 2'd1, 1}, 1'b1);
        @(negedge clk);
        ch_req = 4'b1111;
        #1;
        chk("rg_dv", 32'(dt_valid), 32'd1);
        chk("rg_sample", 32'(dt_sample), 32'(feat(1, 0)));
        chk("rg_res_pulse", 32'(res_valid), 32'd0);
        chk("rg_res_hold", 32'(res_chan), 32'd1);
        chk("rg_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_dv", 32'(dt_valid), 32'd0);
        chk("mid_rst_sample", 32'(dt_sample), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_chan", 32'(res_chan), 32'd0);
        chk("mid_rst_grant", 32'(ch_grant), 32'd0);
        repeat (2) @(negedge clk);
        ch_req = '0;
        reset  = 1'b1;
        quiet  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (res_valid || busy || dt_valid) quiet++;
        end
        chk("post_rst_quiet", 32'(quiet), 32'd0);
        run_txn('{4'b1111, -1, 1, 2'd3, 2'd2, 0}, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dtree_channel_arbiter.md
DTREE_CHANNEL_ARBITER -- requirements
Module: dtree_channel_arbiter

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of requesting electrode channels (2..8).
REQ-002 SHALL have parameter FEATURES, default 3: samples per feature vector sent to the shared dtree.
REQ-003 SHALL have parameter IN_WIDTH, default 10: bits per feature sample.
REQ-004 SHALL have parameter TIMEOUT, default 64: maximum WAIT cycles before abandoning a classification.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-007 SHALL have port ch_req  in  CHANNELS  per-channel request; vector held stable while request is high.
REQ-008 SHALL have port ch_features  in  CHANNELS*FEATURES*IN_WIDTH  packed vectors; channel i at slice i, feature 0 in the low IN_WIDTH bits.
REQ-009 SHALL have port ch_grant  out  CHANNELS  one-hot, one-cycle pulse when the channel's vector is latched.
REQ-010 SHALL have port dt_ready  in  1  dtree ready.
REQ-011 SHALL have port dt_valid  out  1  feature sample valid to dtree.
REQ-012 SHALL have port dt_sample  out  IN_WIDTH  feature sample to dtree.
REQ-013 SHALL have ports dt_level, dt_path  in  2 each  dtree result; dt_out_valid  in  1  result strobe.
REQ-014 SHALL have ports res_valid  out  1, res_chan  out  clog2(CHANNELS), res_level  out  2, res_path  out  2, res_timeout  out  1: tagged result.
REQ-015 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, SEND, WAIT.
REQ-017 In IDLE with any ch_req bit high, SHALL grant the first requesting channel at or after the round-robin pointer, latch its full vector, pulse ch_grant for that cycle, and enter SEND.
REQ-018 After each grant, the pointer SHALL become granted index + 1, wrapping from CHANNELS-1 to 0.
REQ-019 In SEND, dt_valid SHALL be 1 and dt_sample SHALL equal latched feature k, with k starting at 0.
REQ-020 A transfer occurs on a cycle where dt_valid and dt_ready are both 1; k SHALL increment only on a transfer.
REQ-021 With dt_ready low, dt_valid and dt_sample SHALL hold.
REQ-022 After the transfer of feature FEATURES-1, dt_valid SHALL be 0 on the next cycle and the state SHALL be WAIT.
REQ-023 With dt_ready continuously high and a grant at cycle T, features 0..FEATURES-1 SHALL be presented at T+1..T+FEATURES.
REQ-024 On entry to WAIT, a cycle counter SHALL be cleared to 0; it increments once per WAIT cycle.
REQ-025 If dt_out_valid=1 in WAIT, the next cycle SHALL have res_valid=1, res_chan=granted index, res_level=dt_level, res_path=dt_path and res_timeout=0, with the state at IDLE.
REQ-026 If the counter reaches TIMEOUT-1 with dt_out_valid=0, the next cycle SHALL have res_valid=1, res_timeout=1, res_level=0, res_path=0 and res_chan=granted index, with the state at IDLE.
REQ-027 If dt_out_valid=1 on the same cycle the timeout is reached, the result SHALL win and res_timeout SHALL be 0.
REQ-028 res_valid SHALL be a one-cycle pulse; res_chan/level/path/timeout SHALL hold until the next result.
REQ-029 dt_out_valid in IDLE or SEND SHALL be ignored.
REQ-030 A new grant SHALL be possible on the cycle res_valid is high.
REQ-031 ch_req changes on non-granted channels during SEND/WAIT SHALL have no effect; the latched vector SHALL not change until the next grant.

Reset
REQ-032 While reset=0: state IDLE, pointer 0, k 0, counter 0, and all outputs 0 (ch_grant, dt_valid, dt_sample, res_*, busy).
REQ-033 Reset asserted mid-SEND or mid-WAIT SHALL abandon the vector with no res_valid; after release, only a fresh request is served.

Verification
REQ-034 Single request: ch_req=0001, vector {30,20,10}, dt_ready=1 -> ch_grant[0] at T; dt_sample 10,20,30 at T+1..T+3; dt_out_valid at T+6 with level=2, path=01 -> res_valid at T+7 with chan 0, level 2, path 01.
REQ-035 Round-robin fairness: ch_req=1111 held -> grants in order 0,1,2,3,0 across five classifications.
REQ-036 Back-pressure: dt_ready low on the cycle feature 1 is presented -> feature 1 held 2 cycles, no feature skipped or duplicated, exactly 3 transfers.
REQ-037 Timeout: dt_out_valid never asserted -> res_valid with res_timeout=1, level 0, path 0 exactly TIMEOUT cycles after entering WAIT; busy low on that cycle.
REQ-038 Coincidence and reset: dt_out_valid on the timeout cycle -> res_timeout=0; reset=0 mid-SEND -> outputs 0 immediately, no result, pointer back to 0.
